jk_bank_sched: RTL and testbench

Two-requester scheduler that shares one bank of `N_BITS` JK flip-flop cells. It arbitrates round-robin between two command ports and drives the addressed cell's J/K inputs for exactly one cycle. It then returns the cell's new value on a response port. The block sits between control logic and the JK state bank, and it is the only writer of that bank.

---
 rtl/jk_bank_sched_pkg.sv | 24 ++
 rtl/jk_bank_sched_cell.sv | 18 +
 rtl/jk_bank_sched.sv | 120 ++++++++++++
 tb/tb_jk_bank_sched.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/jk_bank_sched_pkg.sv
// Shared op encodings, FSM state type and JK next-state function for the JK bank scheduler.
package jk_bank_sched_pkg;

  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_CLR  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TGL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    APPLY,
    RESP
  } state_t;

  function automatic logic jk_next(input logic q, input logic [1:0] op);
    case (op)
      JK_HOLD: return q;
      JK_CLR:  return 1'b0;
      JK_SET:  return 1'b1;
      default: return ~q;
    endcase
  endfunction

endpackage

// File: rtl/jk_bank_sched_cell.sv
// Single JK flip-flop storage cell; clears asynchronously when rst is low.
module jk_cell
  import jk_bank_sched_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q <= 1'b0;
    else      q <= jk_next(q, {j, k});
  end

endmodule

// File: rtl/jk_bank_sched.sv
// Round-robin two-port scheduler driving a bank of JK cells, one command per IDLE/APPLY/RESP pass.
// Optional grant counters are enabled by defining JK_BANK_SCHED_STATS_EN.
module jk_bank_sched
  import jk_bank_sched_pkg::*;
#(
  parameter int N_BITS = 8,
  parameter int AW     = $clog2(N_BITS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [AW-1:0]     req0_addr,
  input  logic [1:0]        req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [AW-1:0]     req1_addr,
  input  logic [1:0]        req1_op,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [AW-1:0]     rsp_addr,
  output logic              rsp_q,
  output logic              rsp_err,
  output logic [N_BITS-1:0] q
`ifdef JK_BANK_SCHED_STATS_EN
  ,
  output logic [7:0]        grant_cnt0,
  output logic [7:0]        grant_cnt1
`endif
);

  localparam logic [AW:0] N_LIMIT = N_BITS[AW:0];

  state_t        state;
  logic          last;
  logic [1:0]    cmd_op;
  logic          any_valid;
  logic          grant_id;
  logic [AW-1:0] sel_addr;
  logic [1:0]    sel_op;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    any_valid = req0_valid | req1_valid;
    grant_id  = 1'b0;
    if (req0_valid && req1_valid) grant_id = ~last;
    else                          grant_id = req1_valid;
    sel_addr = grant_id ? req1_addr : req0_addr;
    sel_op   = grant_id ? req1_op   : req0_op;
  end

  // Ready is a same-cycle grant: the command is taken on the edge that ends this IDLE cycle.
  assign req0_ready = (state == IDLE) && any_valid && !grant_id;
  assign req1_ready = (state == IDLE) && any_valid &&  grant_id;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      last      <= 1'b1;
      cmd_op    <= JK_HOLD;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_addr  <= '0;
      rsp_q     <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            last     <= grant_id;
            rsp_id   <= grant_id;
            rsp_addr <= sel_addr;
            rsp_err  <= ({1'b0, sel_addr} >= N_LIMIT);
            cmd_op   <= sel_op;
            state    <= APPLY;
          end
        end
        APPLY: begin
          // Mirrors the value the addressed cell captures on this same edge.
          rsp_q     <= rsp_err ? 1'b0 : jk_next(q[rsp_addr], cmd_op);
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < N_BITS; i++) begin : g_cell
    logic hit;
    assign hit = (state == APPLY) && !rsp_err && (rsp_addr == AW'(i));
    jk_cell u_cell (
      .clk (clk),
      .rst (rst),
      .j   (hit & cmd_op[1]),
      .k   (hit & cmd_op[0]),
      .q   (q[i])
    );
  end

`ifdef JK_BANK_SCHED_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_cnt0 <= 8'd0;
      grant_cnt1 <= 8'd0;
    end else begin
      if (req0_ready && grant_cnt0 != 8'hFF) grant_cnt0 <= grant_cnt0 + 8'd1;
      if (req1_ready && grant_cnt1 != 8'hFF) grant_cnt1 <= grant_cnt1 + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_jk_bank_sched.sv
// Directed bench for jk_bank_sched with a 6-cell bank so addresses 6 and 7 are out of range.
module tb_jk_bank_sched;
  import jk_bank_sched_pkg::*;

  localparam int N_BITS = 6;
  localparam int AW     = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              req0_valid = 1'b0, req1_valid = 1'b0;
  logic              req0_ready, req1_ready;
  logic [AW-1:0]     req0_addr = '0, req1_addr = '0;
  logic [1:0]        req0_op = JK_HOLD, req1_op = JK_HOLD;
  logic              rsp_valid;
  logic              rsp_ready = 1'b1;
  logic              rsp_id;
  logic [AW-1:0]     rsp_addr;
  logic              rsp_q;
  logic              rsp_err;
  logic [N_BITS-1:0] q;
`ifdef JK_BANK_SCHED_STATS_EN
  logic [7:0]        grant_cnt0, grant_cnt1;
`endif

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  jk_bank_sched #(.N_BITS(N_BITS)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_addr  (req0_addr),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_addr  (req1_addr),
    .req1_op    (req1_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_addr   (rsp_addr),
    .rsp_q      (rsp_q),
    .rsp_err    (rsp_err),
    .q          (q)
`ifdef JK_BANK_SCHED_STATS_EN
    ,
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Starts one posedge+1 in IDLE; returns whether the right ready pulsed and cycles until rsp_valid.
  task automatic run_cmd(input bit id, input logic [AW-1:0] addr, input logic [1:0] op,
                         output bit rdy, output int lat);
    if (id) begin req1_valid = 1'b1; req1_addr = addr; req1_op = op; end
    else    begin req0_valid = 1'b1; req0_addr = addr; req0_op = op; end
    #1;
    rdy = id ? (req1_ready === 1'b1 && req0_ready === 1'b0)
             : (req0_ready === 1'b1 && req1_ready === 1'b0);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    if (rsp_valid !== 1'b1) lat = 99;
  endtask

  task automatic ack();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #3;
    total++; if (q !== 6'h00) $display("FAIL reset_q: got %h want 00", q); else passed++;
    total++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); else passed++;
    total++; if ({req0_ready, req1_ready} !== 2'b00) $display("FAIL reset_ready: got %b want 00", {req0_ready, req1_ready}); else passed++;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_set_timing();
    bit rdy; int lat;
    req0_valid = 1'b1; req0_addr = 3'd3; req0_op = JK_SET;
    #1;
    total++; if (req0_ready !== 1'b1) $display("FAIL set_ready: got %b want 1", req0_ready); else passed++;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    total++; if (q !== 6'h00 || rsp_valid !== 1'b0) $display("FAIL set_apply: q %h rsp_valid %b want 00/0", q, rsp_valid); else passed++;
    @(posedge clk); #1;
    total++; if (q !== 6'h08) $display("FAIL set_q: got %h want 08", q); else passed++;
    total++; if ({rsp_valid, rsp_id, rsp_addr, rsp_q, rsp_err} !== {1'b1, 1'b0, 3'd3, 1'b1, 1'b0})
      $display("FAIL set_rsp: got v%b id%b a%0d q%b e%b want v1 id0 a3 q1 e0", rsp_valid, rsp_id, rsp_addr, rsp_q, rsp_err);
    else passed++;
    ack();
    total++; if (rsp_valid !== 1'b0) $display("FAIL set_done: rsp_valid %b want 0", rsp_valid); else passed++;
    rdy = 0; lat = 0;
  endtask

  task automatic test_ops();
    bit rdy; int lat;
    logic [1:0] ops [6]   = '{JK_TGL, JK_TGL, JK_CLR, JK_HOLD, JK_SET, JK_HOLD};
    logic [2:0] addrs [6] = '{3'd3, 3'd3, 3'd3, 3'd3, 3'd5, 3'd5};
    logic       exp_q [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [5:0] exp_b [6] = '{6'h00, 6'h08, 6'h00, 6'h00, 6'h20, 6'h20};
    for (int i = 0; i < 6; i++) begin
      run_cmd(1'b0, addrs[i], ops[i], rdy, lat);
      total++; if (!rdy || lat != 2) $display("FAIL op%0d_handshake: rdy %b lat %0d want 1/2", i, rdy, lat); else passed++;
      total++; if (rsp_q !== exp_q[i] || q !== exp_b[i])
        $display("FAIL op%0d_result: rsp_q %b q %h want %b/%h", i, rsp_q, q, exp_q[i], exp_b[i]);
      else passed++;
      ack();
    end
  endtask

  task automatic test_contention();
    bit rdy; int lat; int n; bit got [4];
    run_cmd(1'b1, 3'd0, JK_HOLD, rdy, lat);
    total++; if (!rdy || rsp_id !== 1'b1) $display("FAIL pre_req1: rdy %b id %b want 1/1", rdy, rsp_id); else passed++;
    ack();
    req0_valid = 1'b1; req0_addr = 3'd0; req0_op = JK_HOLD;
    req1_valid = 1'b1; req1_addr = 3'd0; req1_op = JK_HOLD;
    #1;
    n = 0;
    for (int c = 0; c < 30 && n < 4; c++) begin
      if (req0_ready && req1_ready) $display("FAIL both_ready at cycle %0d", cyc);
      if (req0_ready || req1_ready) begin got[n] = req1_ready; n++; end
      @(posedge clk); #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    total++; if (n != 4) $display("FAIL contention_count: got %0d want 4", n); else passed++;
    for (int i = 0; i < 4; i++) begin
      total++; if (got[i] !== i[0]) $display("FAIL contention_grant%0d: got %b want %b", i, got[i], i[0]); else passed++;
    end
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 8) begin @(posedge clk); #1; lat++; end
    ack();
  endtask

  task automatic test_only_req1();
    int n; int t [3];
    req1_valid = 1'b1; req1_addr = 3'd0; req1_op = JK_HOLD;
    #1;
    n = 0;
    for (int c = 0; c < 30 && n < 3; c++) begin
      if (req0_ready) $display("FAIL only_req1_req0_ready at cycle %0d", cyc);
      if (req1_ready) begin t[n] = cyc; n++; end
      @(posedge clk); #1;
    end
    req1_valid = 1'b0;
    total++; if (n != 3) $display("FAIL only_req1_count: got %0d want 3", n); else passed++;
    total++; if (t[1] - t[0] != 3 || t[2] - t[1] != 3)
      $display("FAIL only_req1_spacing: got %0d,%0d want 3,3", t[1] - t[0], t[2] - t[1]);
    else passed++;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 8) begin @(posedge clk); #1; n++; end
    ack();
  endtask

  task automatic test_backpressure();
    bit rdy; int lat;
    rsp_ready = 1'b0;
    run_cmd(1'b1, 3'd1, JK_SET, rdy, lat);
    total++; if (!rdy || lat != 2) $display("FAIL bp_handshake: rdy %b lat %0d want 1/2", rdy, lat); else passed++;
    req0_valid = 1'b1; req0_addr = 3'd1; req0_op = JK_HOLD;
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({rsp_valid, rsp_id, rsp_addr, rsp_q, rsp_err, req0_ready, req1_ready} !== {1'b1, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0})
        $display("FAIL bp_stall%0d: v%b id%b a%0d q%b e%b r0%b r1%b want v1 id1 a1 q1 e0 r00 r10",
                 i, rsp_valid, rsp_id, rsp_addr, rsp_q, rsp_err, req0_ready, req1_ready);
      else passed++;
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    total++; if (req0_ready !== 1'b1 || rsp_valid !== 1'b0)
      $display("FAIL bp_resume: req0_ready %b rsp_valid %b want 1/0", req0_ready, rsp_valid);
    else passed++;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(posedge clk); #1;
    total++; if (rsp_q !== 1'b1 || rsp_id !== 1'b0 || q !== 6'h22)
      $display("FAIL bp_hold: rsp_q %b id %b q %h want 1/0/22", rsp_q, rsp_id, q);
    else passed++;
    ack();
  endtask

  task automatic test_out_of_range();
    bit rdy; int lat;
    run_cmd(1'b0, 3'd7, JK_SET, rdy, lat);
    total++; if (!rdy || lat != 2) $display("FAIL oor_handshake: rdy %b lat %0d want 1/2", rdy, lat); else passed++;
    total++; if (rsp_err !== 1'b1 || rsp_q !== 1'b0 || rsp_addr !== 3'd7)
      $display("FAIL oor_rsp: err %b q %b addr %0d want 1/0/7", rsp_err, rsp_q, rsp_addr);
    else passed++;
    total++; if (q !== 6'h22) $display("FAIL oor_bank: got %h want 22", q); else passed++;
    ack();
  endtask

  task automatic test_reset_mid();
    bit rdy; int lat; bit seen;
    req0_valid = 1'b1; req0_addr = 3'd0; req0_op = JK_SET;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    rst = 1'b0;
    #1;
    total++; if (q !== 6'h00 || rsp_valid !== 1'b0) $display("FAIL rstmid_clear: q %h rsp_valid %b want 00/0", q, rsp_valid); else passed++;
    #2 rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b0 || q !== 6'h00) seen = 1;
    end
    total++; if (seen) $display("FAIL rstmid_dropped: response or bank write after reset"); else passed++;
    run_cmd(1'b1, 3'd2, JK_HOLD, rdy, lat);
    total++; if (!rdy || lat != 2 || rsp_id !== 1'b1 || rsp_q !== 1'b0)
      $display("FAIL rstmid_idle: rdy %b lat %0d id %b q %b want 1/2/1/0", rdy, lat, rsp_id, rsp_q);
    else passed++;
    ack();
  endtask

`ifdef JK_BANK_SCHED_STATS_EN
  task automatic test_stats();
    bit rdy; int lat;
    for (int i = 0; i < 300; i++) begin
      run_cmd(1'b0, 3'd0, JK_HOLD, rdy, lat);
      ack();
    end
    total++; if (grant_cnt0 !== 8'd255 || grant_cnt1 !== 8'd1)
      $display("FAIL stats: cnt0 %0d cnt1 %0d want 255/1", grant_cnt0, grant_cnt1);
    else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_set_timing();
    test_ops();
    test_contention();
    test_only_req1();
    test_backpressure();
    test_out_of_range();
    test_reset_mid();
`ifdef JK_BANK_SCHED_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
